// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall vector
// encodings, FSM state encoding and reset / chip-enable levels.
package pc_ctrl_pkg;

  // Stall vector, bit0 PC .. bit5 WB, 1 = hold
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  // Reset and chip-enable levels
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_wdt.sv
// Stall watchdog: counts consecutive stalled RUN cycles, saturating at
// LIMIT, and raises a sticky timeout flag once the limit is reached.
// Only instantiated when PC_CTRL_STALL_WATCHDOG_EN is defined.
module pc_ctrl_wdt
  import pc_ctrl_pkg::*;
#(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_run,
  output logic timeout
);

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  // Next count: increment while stalled, hold at the limit
  always_comb begin
    cnt_nxt = cnt;
    if (cnt != LIMIT) begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  // Counter clears on any non-stall cycle; timeout is sticky until reset
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt     <= 8'd0;
      timeout <= 1'b0;
    end else if (stall_run) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == LIMIT) begin
        timeout <= 1'b1;
      end
    end else begin
      cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS32 core.
// Sequences fetch enable out of reset and arbitrates exception redirects,
// EX/ID stall requests and branch redirects into the per-stage stall
// vector, pipeline flush and PC load/enable controls.
// Optional stall watchdog: define PC_CTRL_STALL_WATCHDOG_EN.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [7:0]  WDT_LIMIT    = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        excp_flag,
  input  logic [31:0] excp_vector,
  output logic        ce,
  output logic        pc_we,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        wdt_timeout
);

  // The exception cycle itself (in RUN) is flush cycle 1, so the FLUSH
  // state covers cycles 2..FLUSH_CYCLES and exits once the count hits this.
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  pc_state_t  state;
  logic [1:0] fcnt;

  // State, flush counter and registered chip enable
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= ST_RESET;
      ce    <= CHIP_DISABLE;
      fcnt  <= 2'd0;
    end else begin
      ce <= CHIP_ENABLE;
      case (state)
        ST_RESET: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (excp_flag && (FLUSH_CYCLES > 1)) begin
            state <= ST_FLUSH;
            fcnt  <= 2'd1;
          end
        end
        ST_FLUSH: begin
          if (fcnt >= FLUSH_LAST) begin
            state <= ST_RUN;
            fcnt  <= 2'd0;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end
        default: begin
          state <= ST_RESET;
          fcnt  <= 2'd0;
        end
      endcase
    end
  end

  // Pipeline controls from current state and this cycle's requests
  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    pc_we   = 1'b0;
    pc_load = 1'b0;
    pc_next = 32'h0;
    case (state)
      ST_RUN: begin
        if (excp_flag) begin
          flush   = 1'b1;
          pc_load = 1'b1;
          pc_next = excp_vector;
        end else if (stallreq_ex) begin
          // ID holds too, so a concurrent branch is re-presented later
          stall = STALL_EX;
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end else if (branch_flag) begin
          // No flush: the delay slot instruction executes
          pc_load = 1'b1;
          pc_next = branch_target;
        end else begin
          pc_we = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Requests ignored; a late exception finds MEM already cleared
        flush = 1'b1;
        pc_we = 1'b1;
      end
      default: begin
        // Reset: hold everything and pin the PC to the reset vector
        stall   = STALL_ALL;
        flush   = 1'b1;
        pc_load = 1'b1;
        pc_next = RESET_VECTOR;
      end
    endcase
  end

`ifdef PC_CTRL_STALL_WATCHDOG_EN
  logic stall_run;

  assign stall_run = (state == ST_RUN) && stall[0];

  pc_ctrl_wdt #(
    .LIMIT(WDT_LIMIT)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .stall_run(stall_run),
    .timeout  (wdt_timeout)
  );
`else
  assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl (FLUSH_CYCLES=2, WDT_LIMIT=8).
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        excp_flag;
  logic [31:0] excp_vector;
  logic        ce;
  logic        pc_we;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [5:0]  stall;
  logic        flush;
  logic        wdt_timeout;

  int tests_run;
  int tests_failed;

  // Model of the PC register the controller drives
  logic [31:0] pc;

  pc_ctrl #(
    .RESET_VECTOR(32'h0000_0000),
    .FLUSH_CYCLES(2),
    .WDT_LIMIT   (8'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .excp_flag    (excp_flag),
    .excp_vector  (excp_vector),
    .ce           (ce),
    .pc_we        (pc_we),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .stall        (stall),
    .flush        (flush),
    .wdt_timeout  (wdt_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pc = 32'hxxxx_xxxx;
  always @(posedge clk) begin
    if (pc_load) pc <= pc_next;
    else if (pc_we) pc <= pc + 32'd4;
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (ce !== 1'b0 || pc_load !== 1'b1 || pc_next !== 32'h0 || stall !== 6'b111111 || flush !== 1'b1 || pc_we !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d: ce=%b pc_load=%b pc_next=%h stall=%b flush=%b pc_we=%b, want 0 1 00000000 111111 1 0",
                 i, ce, pc_load, pc_next, stall, flush, pc_we);
      end
    end
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ce !== 1'b0 || pc_we !== 1'b0 || pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_release_hold: ce=%b pc_we=%b pc=%h, want 0 0 00000000", ce, pc_we, pc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (ce !== 1'b1 || pc_we !== 1'b1 || pc !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL reset_fetch%0d: ce=%b pc_we=%b pc=%h, want 1 1 %h", i, ce, pc_we, pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_loaduse_branch();
    drive_edge();
    stallreq_id   = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h100;
    @(negedge clk);
    tests_run++;
    if (stall !== 6'b000111 || pc_load !== 1'b0 || pc_we !== 1'b0 || flush !== 1'b0) begin
      tests_failed++;
      $display("FAIL loaduse_stall: stall=%b pc_load=%b pc_we=%b flush=%b, want 000111 0 0 0", stall, pc_load, pc_we, flush);
    end
    drive_edge();
    stallreq_id = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pc_load !== 1'b1 || pc_next !== 32'h100 || stall !== 6'b000000 || flush !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_redirect: pc_load=%b pc_next=%h stall=%b flush=%b, want 1 00000100 000000 0", pc_load, pc_next, stall, flush);
    end
    drive_edge();
    branch_flag = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pc !== 32'h100 || pc_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_pc: pc=%h pc_we=%b, want 00000100 1", pc, pc_we);
    end
  endtask

  task automatic test_divide_stall();
    int          stalled;
    int          we_seen;
    logic [31:0] pc_hold;
    stalled = 0;
    we_seen = 0;
    drive_edge();
    stallreq_ex = 1'b1;
    pc_hold     = pc;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (stall === 6'b001111) stalled++;
      if (pc_we !== 1'b0) we_seen++;
      if (i < 33) drive_edge();
    end
    drive_edge();
    stallreq_ex = 1'b0;
    tests_run++;
    if (stalled != 34 || we_seen != 0) begin
      tests_failed++;
      $display("FAIL divide_stall: stall cycles=%0d pc_we cycles=%0d, want 34 0", stalled, we_seen);
    end
    @(negedge clk);
    tests_run++;
    if (pc_we !== 1'b1 || stall !== 6'b000000 || pc !== pc_hold) begin
      tests_failed++;
      $display("FAIL divide_resume: pc_we=%b stall=%b pc=%h, want 1 000000 %h", pc_we, stall, pc, pc_hold);
    end
  endtask

  task automatic test_exception_over_stall();
    drive_edge();
    excp_flag   = 1'b1;
    excp_vector = 32'h20;
    stallreq_ex = 1'b1;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b1 || pc_load !== 1'b1 || pc_next !== 32'h20 || stall !== 6'b000000) begin
      tests_failed++;
      $display("FAIL excp_cycle1: flush=%b pc_load=%b pc_next=%h stall=%b, want 1 1 00000020 000000", flush, pc_load, pc_next, stall);
    end
    // second exception in FLUSH must be ignored
    drive_edge();
    excp_vector = 32'h40;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b1 || pc_load !== 1'b0 || pc_we !== 1'b1 || stall !== 6'b000000 || pc !== 32'h20) begin
      tests_failed++;
      $display("FAIL excp_cycle2: flush=%b pc_load=%b pc_we=%b stall=%b pc=%h, want 1 0 1 000000 00000020", flush, pc_load, pc_we, stall, pc);
    end
    drive_edge();
    excp_flag = 1'b0;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b0 || stall !== 6'b001111) begin
      tests_failed++;
      $display("FAIL excp_exit: flush=%b stall=%b, want 0 001111", flush, stall);
    end
    drive_edge();
    stallreq_ex = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    excp_flag   = 1'b1;
    excp_vector = 32'h80;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b1 || pc_load !== 1'b1 || pc_next !== 32'h80) begin
      tests_failed++;
      $display("FAIL midflush_excp: flush=%b pc_load=%b pc_next=%h, want 1 1 00000080", flush, pc_load, pc_next);
    end
    drive_edge();
    excp_flag = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b1 || pc_we !== 1'b1 || ce !== 1'b1) begin
      tests_failed++;
      $display("FAIL midflush_state: flush=%b pc_we=%b ce=%b, want 1 1 1", flush, pc_we, ce);
    end
    drive_edge();
    @(negedge clk);
    tests_run++;
    if (ce !== 1'b0 || stall !== 6'b111111 || pc_load !== 1'b1 || pc_next !== 32'h0 || pc_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflush_reset: ce=%b stall=%b pc_load=%b pc_next=%h pc_we=%b, want 0 111111 1 00000000 0", ce, stall, pc_load, pc_next, pc_we);
    end
    drive_edge();
    rst = 1'b0;
    drive_edge();
    @(negedge clk);
    tests_run++;
    if (ce !== 1'b1 || flush !== 1'b0 || pc_we !== 1'b1 || pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL midflush_release: ce=%b flush=%b pc_we=%b pc=%h, want 1 0 1 00000000", ce, flush, pc_we, pc);
    end
    // a fresh exception must again flush exactly two cycles
    drive_edge();
    excp_flag   = 1'b1;
    excp_vector = 32'h180;
    drive_edge();
    excp_flag = 1'b0;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b1 || pc !== 32'h180) begin
      tests_failed++;
      $display("FAIL postreset_flush2: flush=%b pc=%h, want 1 00000180", flush, pc);
    end
    drive_edge();
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b0 || pc_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL postreset_flush_end: flush=%b pc_we=%b, want 0 1", flush, pc_we);
    end
  endtask

  task automatic test_watchdog();
    drive_edge();
    stallreq_ex = 1'b1;
    repeat (7) drive_edge();
    stallreq_ex = 1'b0;
    repeat (2) drive_edge();
    tests_run++;
    if (wdt_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdt_short_stall: wdt_timeout=%b, want 0", wdt_timeout);
    end
    stallreq_id = 1'b1;
    repeat (8) drive_edge();
    stallreq_id = 1'b0;
`ifdef PC_CTRL_STALL_WATCHDOG_EN
    tests_run++;
    if (wdt_timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL wdt_limit: wdt_timeout=%b, want 1", wdt_timeout);
    end
    repeat (5) drive_edge();
    tests_run++;
    if (wdt_timeout !== 1'b1 || stall !== 6'b000000) begin
      tests_failed++;
      $display("FAIL wdt_sticky: wdt_timeout=%b stall=%b, want 1 000000", wdt_timeout, stall);
    end
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    tests_run++;
    if (wdt_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdt_reset_clear: wdt_timeout=%b, want 0", wdt_timeout);
    end
    drive_edge();
`else
    repeat (5) drive_edge();
    tests_run++;
    if (wdt_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdt_disabled: wdt_timeout=%b, want 0", wdt_timeout);
    end
`endif
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    stallreq_id   = 1'b0;
    stallreq_ex   = 1'b0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    excp_flag     = 1'b0;
    excp_vector   = 32'h0;
    #1;
    test_reset();
    test_loaduse_branch();
    test_divide_stall();
    test_exception_over_stall();
    test_reset_mid_flush();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS32 core.
- Owns the fetch-enable sequence out of reset and arbitrates stall requests, branch redirects and exception redirects.
- Produces the per-stage stall vector, the pipeline flush, and the PC load/enable controls consumed by the PC register and the IF/ID..MEM/WB pipeline registers.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value forced during reset and boot.
- FLUSH_CYCLES, 1, number of cycles flush is held after an exception (1..3).
- WDT_LIMIT, 8'd255, consecutive-stall cycle limit (only used with the optional feature).

Ports:
- clk  in  1  core clock, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_id  in  1  ID stage requests a stall (load-use hazard).
- stallreq_ex  in  1  EX stage requests a stall (multi-cycle mul/div).
- branch_flag  in  1  ID resolved a taken branch/jump this cycle.
- branch_target  in  32  branch destination, byte address.
- excp_flag  in  1  exception/eret committed in MEM this cycle.
- excp_vector  in  32  exception handler or EPC address.
- ce  out  1  instruction memory chip enable, registered.
- pc_we  out  1  PC may advance by 4 this cycle.
- pc_load  out  1  PC loads pc_next on the next edge (overrides pc_we).
- pc_next  out  32  redirect address.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush  out  1  clear IF/ID, ID/EX, EX/MEM to NOP.
- wdt_timeout  out  1  sticky stall-watchdog flag.

Behaviour:
- Registered FSM with states RESET, RUN, FLUSH. stall, flush, pc_we, pc_load and pc_next are combinational from state and inputs.
- rst=1 on an edge: state<=RESET, ce<=0, flush counter<=0, watchdog counter<=0, wdt_timeout<=0. rst overrides all inputs, including mid-flush and mid-stall.
- RESET outputs: ce=0, stall=6'b111111, flush=1, pc_load=1, pc_next=RESET_VECTOR, pc_we=0.
- RESET -> RUN on the first edge with rst=0; ce<=1 on that same edge.
- Net effect: the PC holds RESET_VECTOR for one cycle after reset release, then fetch starts. The first fetched address is RESET_VECTOR, not RESET_VECTOR+4.
- RUN priority, highest first: excp_flag > stallreq_ex > stallreq_id > branch_flag > normal.
  - excp_flag: flush=1, stall=0, pc_load=1, pc_next=excp_vector. State<=FLUSH if FLUSH_CYCLES>1, otherwise it stays RUN.
  - stallreq_ex: stall=6'b001111, pc_we=0, pc_load=0. A concurrent branch is ignored because ID holds and re-presents it.
  - stallreq_id: stall=6'b000111, pc_we=0, pc_load=0. A concurrent branch is ignored.
  - branch_flag: stall=0, pc_load=1, pc_next=branch_target. No flush: the delay slot executes.
  - normal: stall=0, flush=0, pc_we=1, pc_load=0, pc_next=32'h0.
- FLUSH: flush=1, stall=0, pc_we=1, all requests ignored. A counter starting at 1 counts to FLUSH_CYCLES, then the FSM returns to RUN.
- excp_flag arriving in FLUSH is ignored; MEM is already cleared.
- ce stays 1 in every state except RESET.
- branch_target and excp_vector pass through unmodified. Alignment is checked elsewhere.

Optional Feature:
- Macro: PC_CTRL_STALL_WATCHDOG_EN.
- With the macro defined:
  - An 8-bit counter increments on each RUN cycle where stall[0]=1, saturating at WDT_LIMIT.
  - It clears on any non-stall cycle.
  - When it reaches WDT_LIMIT, wdt_timeout<=1 and stays set until rst.
  - It has no effect on the pipeline.
- Without the macro: no counter is built and wdt_timeout is tied to 0.

Decomposition:
- Shared defines header gets:
  - stall vector encodings: STALL_NONE 6'b000000, STALL_ID 6'b000111, STALL_EX 6'b001111, STALL_ALL 6'b111111;
  - FSM state encodings;
  - the existing reset/chip-enable level constants.
- One sub-module is natural: pc_ctrl_wdt, the watchdog counter, instantiated only under the macro.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0 -> ce=0 and pc_load=1 with pc_next=0 while reset; ce=1 on the first edge after release; pc_we=1 from the next cycle; fetch addresses 0,4,8.
- Load-use plus branch: stallreq_id=1 with branch_flag=1, target 32'h100 -> stall=6'b000111, pc_load=0. Next cycle stallreq_id=0, branch_flag=1 -> pc_load=1, pc_next=32'h100.
- Divide stall: stallreq_ex=1 for 34 cycles -> stall=6'b001111 for exactly 34 cycles, pc_we=0 throughout, resumes pc_we=1.
- Exception over stall: excp_flag=1, excp_vector=32'h20, stallreq_ex=1, FLUSH_CYCLES=2 -> flush=1 for 2 cycles, pc_load=1 with pc_next=32'h20 in cycle 1, stall=0 both cycles.
- Reset mid-flush: rst=1 in the second FLUSH cycle -> RESET outputs on the next edge; the flush counter does not carry over after release.
- Watchdog (macro on, WDT_LIMIT=8): stallreq_ex held 8 cycles -> wdt_timeout=1 and stays set after the stall drops. A 7-cycle stall leaves it 0.
